munoc_wreq_packetizer: RTL and testbench
========================================

MUNOC_WREQ_PACKETIZER -- requirements
Module: munoc_wreq_packetizer

Interface
REQ-001 SHALL have parameter BW_ADDR, default 32, AXI address width.
REQ-002 SHALL have parameter BW_DATA, default 32, AXI write-data width (multiple of 8).
REQ-003 SHALL have parameter BW_TID, default 4, AXI transaction-ID width.
REQ-004 SHALL have parameter BW_NODE_ID, default 4, NoC node-ID width.
REQ-005 SHALL have parameter SRC_NODE_ID, default 0, this master's node ID.
REQ-006 SHALL have derived localparam BW_FLIT = 2 + max(2*BW_NODE_ID+BW_TID+BW_ADDR+13, 9*BW_DATA/8).
REQ-007 Ports: clk input 1, clock; one clock, reset is asynchronous and active-high.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 awvalid in 1, awready out 1, awaddr in BW_ADDR, awid in BW_TID, awlen in 8, awsize in 3, awburst in 2: AXI AW channel.
REQ-010 aw_dest_id  in  BW_NODE_ID  decoded target slave node, sampled with AW.
REQ-011 wvalid in 1, wready out 1, wdata in BW_DATA, wstrb in BW_DATA/8, wlast in 1: AXI W channel.
REQ-012 flit_valid out 1, flit_data out BW_FLIT, flit_ready in 1: request link toward router.
REQ-013 err_len  out  1  sticky flag: wlast disagreed with awlen.

Function
REQ-014 flit_data SHALL be {head, tail, payload}, head at bit BW_FLIT-1, tail at BW_FLIT-2, payload right-aligned, unused bits zero.
REQ-015 Header payload, MSB first: dest_id, SRC_NODE_ID, awid, awaddr, awlen, awsize, awburst.
REQ-016 Data payload: byte lane i packed as {wstrb[i], wdata[8i+7:8i]}, lane 0 at payload MSB.
REQ-017 FSM states IDLE, HEAD, DATA; reset state IDLE.
REQ-018 IDLE: awready=1 iff output slot empty or draining this cycle; on AW handshake capture AW fields, load header into output slot, go to DATA (HEAD state used only when slot busy at AW acceptance -- latched, header loaded when slot frees).
REQ-019 Header flit SHALL appear on flit_valid the cycle after the AW handshake when the slot is free.
REQ-020 DATA: wready=1 iff output slot empty or flit_ready=1 this cycle; awready=0.
REQ-021 Beat counter (8-bit) SHALL clear on AW accept and increment per W handshake; tail=1 when counter==captured awlen.
REQ-022 After tail beat handshake FSM SHALL return to IDLE; back-to-back AW accepted no earlier than the cycle after tail enters the slot.
REQ-023 awlen=0: single data flit with tail=1; header tail is always 0.
REQ-024 Tail derives from counter, not wlast; wlast!=(counter==awlen) on any beat SHALL set err_len, cleared only by reset.
REQ-025 Output slot: one register; flit_valid held and flit_data stable until flit_ready=1; new flit may load in the same cycle the old one drains (full throughput, one flit/cycle).
REQ-026 W channel SHALL be ignored (wready=0) in IDLE and HEAD.

Reset
REQ-027 On rst: state IDLE, flit_valid=0, flit_data=0, awready=0 during reset, wready=0, counter=0, err_len=0, captured AW fields=0.
REQ-028 Reset mid-packet SHALL discard partial packet; no tail emitted.

Structure
REQ-029 Flit field widths, head/tail bit positions and FSM encoding SHALL live in the shared munoc package/include (munoc_network_link).
REQ-030 Output slot SHALL be a sub-module munoc_flit_slot (valid/ready one-entry register), reusable by the read-request packetizer.

Verification
REQ-031 AW addr=0x1000,id=3,len=0,dest=2; W data=0xAABBCCDD,strb=0xF,last=1; flit_ready=1 -> header cycle+1, one data flit tail=1, payload 0x1AA1BB1CC1DD... order per REQ-016.
REQ-032 len=3, continuous W, flit_ready=1 -> 5 consecutive flits, tail only on 4th data flit, no bubbles.
REQ-033 len=3, flit_ready toggling 1,0 -> flit_data stable while stalled, wready=0 during stall, 5 flits total, order preserved.
REQ-034 len=1, wlast=1 on first beat -> err_len=1, still 2 data flits, tail on second.
REQ-035 Assert rst after header+1 data flit of len=3 -> flit_valid=0 next cycle, IDLE, subsequent len=0 packet correct.
REQ-036 Two AWs back-to-back -> second awready held 0 until first tail loaded; headers/IDs not interleaved.

Source files
------------

// File: rtl/munoc_network_link.sv
// Shared muNoC link definitions: flit framing (head/tail bit positions,
// payload widths) and the packetizer FSM state encoding.
package munoc_network_link;

  // awlen(8) + awsize(3) + awburst(2) ride in every header after the IDs and address
  localparam int AW_CTRL_BITS = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } pkt_state_e;

  function automatic int hdr_payload_bits(input int bw_node_id, input int bw_tid,
                                          input int bw_addr);
    return 2 * bw_node_id + bw_tid + bw_addr + AW_CTRL_BITS;
  endfunction

  function automatic int data_payload_bits(input int bw_data);
    return 9 * bw_data / 8;
  endfunction

  function automatic int flit_bits(input int bw_node_id, input int bw_tid,
                                   input int bw_addr, input int bw_data);
    int hdr;
    int dat;
    hdr = hdr_payload_bits(bw_node_id, bw_tid, bw_addr);
    dat = data_payload_bits(bw_data);
    return 2 + ((hdr > dat) ? hdr : dat);
  endfunction

  function automatic int head_bit(input int bw_flit);
    return bw_flit - 1;
  endfunction

  function automatic int tail_bit(input int bw_flit);
    return bw_flit - 2;
  endfunction

endpackage

// File: rtl/munoc_wreq_packetizer_if.sv
// AXI AW/W channels plus the request flit link of the write-request packetizer.
// master = AXI/router side driver, slave = the packetizer itself.
interface munoc_wreq_packetizer_if
  import munoc_network_link::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_TID     = 4,
  parameter int BW_NODE_ID = 4
);
  localparam int BW_FLIT = flit_bits(BW_NODE_ID, BW_TID, BW_ADDR, BW_DATA);

  logic                    awvalid;
  logic                    awready;
  logic [BW_ADDR-1:0]      awaddr;
  logic [BW_TID-1:0]       awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [BW_NODE_ID-1:0]   aw_dest_id;

  logic                    wvalid;
  logic                    wready;
  logic [BW_DATA-1:0]      wdata;
  logic [BW_DATA/8-1:0]    wstrb;
  logic                    wlast;

  logic                    flit_valid;
  logic [BW_FLIT-1:0]      flit_data;
  logic                    flit_ready;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, aw_dest_id,
    output wvalid, wdata, wstrb, wlast,
    output flit_ready,
    input  awready, wready, flit_valid, flit_data
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, aw_dest_id,
    input  wvalid, wdata, wstrb, wlast,
    input  flit_ready,
    output awready, wready, flit_valid, flit_data
  );

endinterface

// File: rtl/munoc_flit_slot.sv
// One-entry valid/ready output register shared by the muNoC request packetizers.
// A new flit may be loaded in the same cycle the held one drains.
module munoc_flit_slot #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [BW-1:0] load_data,
  output logic          can_load,
  output logic          out_valid,
  output logic [BW-1:0] out_data,
  input  logic          out_ready
);

  assign can_load = !out_valid || out_ready;

  // data is only overwritten on load, so it stays stable through a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/munoc_wreq_packetizer.sv
// Converts one AXI write burst (AW + W beats) into a muNoC request packet:
// a header flit followed by one data flit per beat, tail on the last beat.
module munoc_wreq_packetizer
  import munoc_network_link::*;
#(
  parameter int BW_ADDR     = 32,
  parameter int BW_DATA     = 32,
  parameter int BW_TID      = 4,
  parameter int BW_NODE_ID  = 4,
  parameter int SRC_NODE_ID = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  munoc_wreq_packetizer_if.slave  bus,
  output logic                    err_len
);

  localparam int BW_HDR   = hdr_payload_bits(BW_NODE_ID, BW_TID, BW_ADDR);
  localparam int BW_DPL   = data_payload_bits(BW_DATA);
  localparam int BW_FLIT  = flit_bits(BW_NODE_ID, BW_TID, BW_ADDR, BW_DATA);
  localparam int HEAD_BIT = head_bit(BW_FLIT);
  localparam int TAIL_BIT = tail_bit(BW_FLIT);
  localparam int N_LANES  = BW_DATA / 8;
  localparam logic [BW_NODE_ID-1:0] SRC_ID = BW_NODE_ID'(SRC_NODE_ID);

  pkt_state_e state;
  pkt_state_e state_next;

  logic [BW_ADDR-1:0]    addr_q;
  logic [BW_TID-1:0]     id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [BW_NODE_ID-1:0] dest_q;
  logic [7:0]            beat_cnt;

  logic                  slot_free;
  logic                  slot_load;
  logic [BW_FLIT-1:0]    slot_data;
  logic                  capture_aw;
  logic                  w_hs;
  logic                  tail_beat;

  function automatic logic [BW_FLIT-1:0] make_header(
    input logic [BW_NODE_ID-1:0] dest,
    input logic [BW_TID-1:0]     id,
    input logic [BW_ADDR-1:0]    addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [BW_FLIT-1:0] f;
    f = '0;
    f[HEAD_BIT] = 1'b1;
    f[BW_HDR-1:0] = {dest, SRC_ID, id, addr, len, size, burst};
    return f;
  endfunction

  // byte lane 0 lands at the payload MSB, each lane carried as {strb, byte}
  function automatic logic [BW_FLIT-1:0] make_data(
    input logic [BW_DATA-1:0]   data,
    input logic [N_LANES-1:0]   strb,
    input logic                 tail
  );
    logic [BW_FLIT-1:0] f;
    f = '0;
    f[TAIL_BIT] = tail;
    for (int i = 0; i < N_LANES; i++) begin
      f[BW_DPL-1-9*i -: 9] = {strb[i], data[8*i +: 8]};
    end
    return f;
  endfunction

  assign tail_beat = (beat_cnt == len_q);
  assign w_hs      = (state == ST_DATA) && bus.wvalid && slot_free;

  munoc_flit_slot #(.BW(BW_FLIT)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (slot_data),
    .can_load  (slot_free),
    .out_valid (bus.flit_valid),
    .out_data  (bus.flit_data),
    .out_ready (bus.flit_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HEAD holds an accepted AW whose header could not enter the slot yet;
  // the header is then rebuilt from the captured fields.
  always_comb begin
    state_next  = state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    slot_load   = 1'b0;
    slot_data   = '0;
    capture_aw  = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.awready = slot_free && !rst;
        if (bus.awvalid && bus.awready) begin
          capture_aw = 1'b1;
          if (slot_free) begin
            slot_load  = 1'b1;
            slot_data  = make_header(bus.aw_dest_id, bus.awid, bus.awaddr,
                                     bus.awlen, bus.awsize, bus.awburst);
            state_next = ST_DATA;
          end else begin
            state_next = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (slot_free) begin
          slot_load  = 1'b1;
          slot_data  = make_header(dest_q, id_q, addr_q, len_q, size_q, burst_q);
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        bus.wready = slot_free;
        if (w_hs) begin
          slot_load = 1'b1;
          slot_data = make_data(bus.wdata, bus.wstrb, tail_beat);
          if (tail_beat) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // tail comes from the beat count; wlast is only cross-checked into err_len
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      dest_q   <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      if (capture_aw) begin
        addr_q   <= bus.awaddr;
        id_q     <= bus.awid;
        len_q    <= bus.awlen;
        size_q   <= bus.awsize;
        burst_q  <= bus.awburst;
        dest_q   <= bus.aw_dest_id;
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (w_hs && (bus.wlast != tail_beat)) begin
        err_len <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_munoc_wreq_packetizer.sv
// Directed bench for munoc_wreq_packetizer: a packet-level model predicts the
// flit stream and handshake readiness, checked every cycle at the falling edge.
module tb_munoc_wreq_packetizer;
  import munoc_network_link::*;

  localparam int BW_ADDR     = 32;
  localparam int BW_DATA     = 32;
  localparam int BW_TID      = 4;
  localparam int BW_NODE_ID  = 4;
  localparam int SRC_NODE_ID = 5;
  localparam int BW_FLIT     = flit_bits(BW_NODE_ID, BW_TID, BW_ADDR, BW_DATA);

  typedef logic [63:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_len;

  munoc_wreq_packetizer_if #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_TID(BW_TID), .BW_NODE_ID(BW_NODE_ID)
  ) bus ();

  munoc_wreq_packetizer #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_TID(BW_TID),
    .BW_NODE_ID(BW_NODE_ID), .SRC_NODE_ID(SRC_NODE_ID)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ready_mode = 0;

  flit_t exp_q[$];
  flit_t out_log[$];
  int    out_cyc[$];
  int    aw_cyc[$];
  int    tail_cyc[$];

  logic  in_packet = 1'b0;
  logic  model_err = 1'b0;
  logic  hdr_due = 1'b0;
  logic  slot_free_m;
  logic  tail_m;
  int    model_len = 0;
  int    model_beat = 0;

  task automatic checkOutput(input string name, input flit_t actual, input flit_t expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // header payload assembled field by field, MSB first
  function automatic flit_t modelHeader(input int dest, input int id, input longint addr,
                                        input int len, input int size, input int burst);
    flit_t p;
    p = flit_t'(dest);
    p = (p << BW_NODE_ID) | flit_t'(SRC_NODE_ID);
    p = (p << BW_TID) | flit_t'(id);
    p = (p << BW_ADDR) | flit_t'(addr);
    p = (p << 8) | flit_t'(len);
    p = (p << 3) | flit_t'(size);
    p = (p << 2) | flit_t'(burst);
    return (flit_t'(2) << (BW_FLIT - 2)) | p;
  endfunction

  function automatic flit_t modelData(input logic [31:0] data, input logic [3:0] strb,
                                      input logic tail);
    flit_t p;
    p = 0;
    for (int lane = 0; lane < 4; lane++) begin
      p = (p << 9) | flit_t'({strb[lane], data[8*lane +: 8]});
    end
    return (flit_t'(tail) << (BW_FLIT - 2)) | p;
  endfunction

  function automatic flit_t logAt(input int i);
    if (i < out_log.size()) return out_log[i];
    return '1;
  endfunction

  // Single compare process: readiness, header latency, err_len and flit order
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      checkOutput("rst_flit_valid", flit_t'(bus.flit_valid), 0);
      checkOutput("rst_flit_data", flit_t'(bus.flit_data), 0);
      checkOutput("rst_awready", flit_t'(bus.awready), 0);
      checkOutput("rst_wready", flit_t'(bus.wready), 0);
      checkOutput("rst_err_len", flit_t'(err_len), 0);
      exp_q.delete();
      in_packet = 1'b0;
      model_err = 1'b0;
      hdr_due = 1'b0;
    end else begin
      slot_free_m = !bus.flit_valid || bus.flit_ready;
      checkOutput("awready", flit_t'(bus.awready), flit_t'(!in_packet && slot_free_m));
      checkOutput("wready", flit_t'(bus.wready), flit_t'(in_packet && slot_free_m));
      checkOutput("err_len", flit_t'(err_len), flit_t'(model_err));
      if (hdr_due) checkOutput("hdr_latency", flit_t'(bus.flit_valid), 1);
      hdr_due = 1'b0;
      if (bus.flit_valid && bus.flit_ready) begin
        out_log.push_back(flit_t'(bus.flit_data));
        out_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_flit: got 0x%0h, required no flit (cycle %0d)",
                   bus.flit_data, cycle);
        end else begin
          checkOutput("flit", flit_t'(bus.flit_data), exp_q.pop_front());
        end
      end
      if (bus.awvalid && bus.awready) begin
        exp_q.push_back(modelHeader(int'(bus.aw_dest_id), int'(bus.awid), longint'(bus.awaddr),
                                    int'(bus.awlen), int'(bus.awsize), int'(bus.awburst)));
        in_packet = 1'b1;
        model_len = int'(bus.awlen);
        model_beat = 0;
        hdr_due = 1'b1;
        aw_cyc.push_back(cycle);
      end
      if (bus.wvalid && bus.wready) begin
        tail_m = (model_beat == model_len);
        exp_q.push_back(modelData(bus.wdata, bus.wstrb, tail_m));
        if (bus.wlast != tail_m) model_err = 1'b1;
        model_beat++;
        if (tail_m) begin
          in_packet = 1'b0;
          tail_cyc.push_back(cycle);
        end
      end
    end
  end

  // flit_ready: mode 0 always ready, mode 1 alternates every cycle
  initial begin
    bus.flit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.flit_ready = 1'b1;
      else bus.flit_ready = ~bus.flit_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitReady(input bit is_w, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(is_w ? bus.wready : bus.awready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: ready stayed 0, required 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendAw(input int dest, input int id, input logic [31:0] addr, input int len);
    bus.awvalid    = 1'b1;
    bus.aw_dest_id = 4'(dest);
    bus.awid       = 4'(id);
    bus.awaddr     = addr;
    bus.awlen      = 8'(len);
    bus.awsize     = 3'd2;
    bus.awburst    = 2'd1;
    waitReady(1'b0, "aw_timeout");
    bus.awvalid = 1'b0;
  endtask

  task automatic sendW(input int len, input logic [31:0] data, input logic [3:0] strb,
                       input int flip, input int max_beats);
    for (int b = 0; b <= len && b < max_beats; b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = data + 32'(b) * 32'h11111111;
      bus.wstrb  = strb ^ 4'(b);
      bus.wlast  = (b == len) ^ (b == flip);
      waitReady(1'b1, "w_timeout");
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic applyStimulus(input int dest, input int id, input logic [31:0] addr,
                               input int len, input logic [31:0] data, input logic [3:0] strb,
                               input int flip);
    sendAw(dest, id, addr, len);
    sendW(len, data, strb, flip, 256);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.flit_valid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_timeout", flit_t'(guard >= 100), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    out_log.delete();
    out_cyc.delete();
    aw_cyc.delete();
    tail_cyc.delete();
  endtask

  initial begin
    flit_t f;
    bus.awvalid = 1'b0;
    bus.awaddr = '0;
    bus.awid = '0;
    bus.awlen = '0;
    bus.awsize = '0;
    bus.awburst = '0;
    bus.aw_dest_id = '0;
    bus.wvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single-beat packet, hand-computed flits");
    clearLogs();
    applyStimulus(2, 3, 32'h1000, 0, 32'hAABBCCDD, 4'hF, -1);
    drain();
    checkOutput("t1_count", flit_t'(out_log.size()), 2);
    checkOutput("t1_header", logAt(0), 64'h044A600002000009);
    checkOutput("t1_data", logAt(1), 64'h0200000EEF3377AA);

    $display("[TB] len=3 burst, continuous W, router always ready");
    clearLogs();
    applyStimulus(1, 4, 32'h0000_2040, 3, 32'h1020_3040, 4'hF, -1);
    drain();
    checkOutput("t2_count", flit_t'(out_log.size()), 5);
    checkOutput("t2_no_bubbles",
                flit_t'((out_cyc.size() == 5) ? (out_cyc[4] - out_cyc[0]) : -1), 4);
    f = logAt(4);
    checkOutput("t2_last_tail", flit_t'(f[BW_FLIT-2]), 1);
    f = logAt(3);
    checkOutput("t2_third_no_tail", flit_t'(f[BW_FLIT-2]), 0);

    $display("[TB] len=3 burst with router ready toggling");
    clearLogs();
    ready_mode = 1;
    applyStimulus(9, 12, 32'hDEAD_BEE0, 3, 32'h0F1E_2D3C, 4'hA, -1);
    drain();
    ready_mode = 0;
    checkOutput("t3_count", flit_t'(out_log.size()), 5);

    $display("[TB] len=1 burst with early wlast");
    clearLogs();
    applyStimulus(6, 1, 32'h0000_0100, 1, 32'h7788_99AA, 4'h3, 0);
    drain();
    checkOutput("t4_count", flit_t'(out_log.size()), 3);
    checkOutput("t4_err_len", flit_t'(err_len), 1);
    f = logAt(2);
    checkOutput("t4_tail_second_beat", flit_t'(f[BW_FLIT-2]), 1);

    $display("[TB] reset in the middle of a len=3 packet");
    clearLogs();
    sendAw(1, 7, 32'h0000_2000, 3);
    sendW(3, 32'h0102_0304, 4'hF, -1, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_valid_after_rst", flit_t'(bus.flit_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t5_err_cleared", flit_t'(err_len), 0);
    clearLogs();
    applyStimulus(3, 9, 32'h0000_3000, 0, 32'h5566_7788, 4'h5, -1);
    drain();
    checkOutput("t5_count", flit_t'(out_log.size()), 2);
    checkOutput("t5_header", logAt(0), modelHeader(3, 9, 64'h3000, 0, 2, 1));

    $display("[TB] back-to-back AW requests");
    clearLogs();
    fork
      begin
        sendAw(4, 2, 32'h0000_4000, 2);
        sendAw(5, 11, 32'h0000_5000, 1);
      end
      begin
        sendW(2, 32'hCAFE_0000, 4'hF, -1, 256);
        sendW(1, 32'hBEEF_0000, 4'hC, -1, 256);
      end
    join
    drain();
    checkOutput("t6_count", flit_t'(out_log.size()), 7);
    checkOutput("t6_aw_count", flit_t'(aw_cyc.size()), 2);
    checkOutput("t6_aw_after_tail",
                flit_t'((aw_cyc.size() == 2 && tail_cyc.size() >= 1) ? (aw_cyc[1] > tail_cyc[0]) : 0), 1);
    checkOutput("t6_second_header", logAt(4), modelHeader(5, 11, 64'h5000, 1, 2, 1));

    checkOutput("queue_empty", flit_t'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
